// File: rtl/mac_col_feeder.sv
// mac_col_feeder
//
// Sequencer at the top edge of one systolic column of mac_pe instances. A job
// collects ROWS packed weights (upper nibble shift, lower nibble mantissa),
// shifts them down the column's sum chain with load_weight_en held high, then
// streams k_len activation vectors into the rows' in_a inputs through a row
// skew line, and finally issues FLUSH_CYC zero-activation cycles so the bottom
// of the column drains completely.
//
// Ports
//   clk_i              clock
//   rst_i              synchronous, active-high reset
//   start_i            one-cycle job request, sampled only while idle
//   k_len_i            activation vectors in the job, sampled with start_i
//   w_valid_i/w_ready_o/w_data_i   weight handshake, row 0 first
//   a_valid_i/a_ready_o/a_data_i   activation handshake, lane r = row r
//   load_weight_en_o   to every PE's load_weight_en
//   sum_out_o          to the top PE's in_sum (weights, then zero seed)
//   a_out_o            lane r to row r in_a, delayed r cycles beyond lane 0
//   a_lane_vld_o       lane r carries a real activation (not a bubble)
//   busy_o             high whenever a job is in progress
//   done_o             one-cycle pulse on the last flush cycle
//
// Every output comes straight from a flop and resets to zero.

module mac_col_feeder #(
  parameter int unsigned ROWS      = 4,
  parameter int unsigned FLUSH_CYC = ROWS + 3
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic [15:0]         k_len_i,
  input  logic                w_valid_i,
  output logic                w_ready_o,
  input  logic [7:0]          w_data_i,
  input  logic                a_valid_i,
  output logic                a_ready_o,
  input  logic [8*ROWS-1:0]   a_data_i,
  output logic                load_weight_en_o,
  output logic [31:0]         sum_out_o,
  output logic [8*ROWS-1:0]   a_out_o,
  output logic [ROWS-1:0]     a_lane_vld_o,
  output logic                busy_o,
  output logic                done_o
);

  localparam int unsigned WcntW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned FcntW = $clog2(FLUSH_CYC + 1);

  // Terminal counts: the FSM leaves WFILL/WLOAD/FLUSH on these, never wraps.
  localparam logic [WcntW-1:0] WLast = WcntW'(ROWS - 1);
  localparam logic [FcntW-1:0] FLast = FcntW'(FLUSH_CYC - 1);

  typedef enum logic [2:0] {
    StIdle,
    StWfill,
    StWload,
    StStream,
    StFlush
  } state_e;

  state_e             state_q, state_d;
  logic [WcntW-1:0]   wcnt_q, wcnt_d;
  logic [15:0]        kcnt_q, kcnt_d;
  logic [15:0]        klen_q, klen_d;
  logic [FcntW-1:0]   fcnt_q, fcnt_d;
  logic [7:0]         wbuf_q [ROWS];
  logic [7:0]         wbuf_d [ROWS];

  // Registered outputs and their next values.
  logic               busy_q, busy_d;
  logic               w_ready_q, w_ready_d;
  logic               a_ready_q, a_ready_d;
  logic               done_q, done_d;
  logic               lwe_q, lwe_d;
  logic [7:0]         sum_q, sum_d;

  logic               w_acc;
  logic               a_acc;

  assign w_acc = w_valid_i && w_ready_q;
  assign a_acc = a_valid_i && a_ready_q;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    kcnt_d  = kcnt_q;
    klen_d  = klen_q;
    fcnt_d  = fcnt_q;
    wbuf_d  = wbuf_q;
    lwe_d   = 1'b0;
    sum_d   = '0;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          klen_d  = k_len_i;
          wcnt_d  = '0;
          state_d = StWfill;
        end
      end

      StWfill: begin
        if (w_acc) begin
          wbuf_d[wcnt_q] = w_data_i;
          if (wcnt_q == WLast) begin
            // The newest weight is the first one pushed down the chain, so it
            // goes out directly rather than via the buffer.
            wcnt_d  = '0;
            state_d = StWload;
            lwe_d   = 1'b1;
            sum_d   = w_data_i;
          end else begin
            wcnt_d = wcnt_q + 1'b1;
          end
        end
      end

      StWload: begin
        // wcnt_q is the index of the load cycle currently on the outputs.
        if (wcnt_q == WLast) begin
          wcnt_d = '0;
          if (klen_q == 16'd0) begin
            state_d = StFlush;
            fcnt_d  = '0;
          end else begin
            state_d = StStream;
            kcnt_d  = '0;
          end
        end else begin
          wcnt_d = wcnt_q + 1'b1;
          lwe_d  = 1'b1;
          // Reverse row order: the bottom row's weight must enter first.
          sum_d  = wbuf_q[WLast - 1'b1 - wcnt_q];
        end
      end

      StStream: begin
        if (a_acc) begin
          kcnt_d = kcnt_q + 16'd1;
          if (kcnt_q == klen_q - 16'd1) begin
            state_d = StFlush;
            fcnt_d  = '0;
          end
        end
      end

      StFlush: begin
        if (fcnt_q == FLast) begin
          state_d = StIdle;
          fcnt_d  = '0;
        end else begin
          fcnt_d = fcnt_q + 1'b1;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state
  // they describe once registered.
  always_comb begin
    busy_d    = (state_d != StIdle);
    w_ready_d = (state_d == StWfill);
    a_ready_d = (state_d == StStream);
    done_d    = (state_d == StFlush) && (fcnt_d == FLast);
  end

  // --------------------------------------------------------------------------
  // State and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      wcnt_q    <= '0;
      kcnt_q    <= '0;
      klen_q    <= '0;
      fcnt_q    <= '0;
      busy_q    <= 1'b0;
      w_ready_q <= 1'b0;
      a_ready_q <= 1'b0;
      done_q    <= 1'b0;
      lwe_q     <= 1'b0;
      sum_q     <= '0;
      for (int i = 0; i < ROWS; i++) begin
        wbuf_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      kcnt_q    <= kcnt_d;
      klen_q    <= klen_d;
      fcnt_q    <= fcnt_d;
      busy_q    <= busy_d;
      w_ready_q <= w_ready_d;
      a_ready_q <= a_ready_d;
      done_q    <= done_d;
      lwe_q     <= lwe_d;
      sum_q     <= sum_d;
      for (int i = 0; i < ROWS; i++) begin
        wbuf_q[i] <= wbuf_d[i];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Skew line: lane r is a (r+1)-deep shift of {valid, data}. Non-accept
  // cycles inject zero bubbles, so the line is all-zero outside a job.
  // --------------------------------------------------------------------------
  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    logic [8:0]         lane_in;
    logic [9*(r+1)-1:0] sh_q;

    assign lane_in = a_acc ? {1'b1, a_data_i[8*r +: 8]} : 9'd0;

    if (r == 0) begin : g_d0
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          sh_q <= '0;
        end else begin
          sh_q <= lane_in;
        end
      end
    end else begin : g_dn
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          sh_q <= '0;
        end else begin
          sh_q <= {sh_q[9*r-1:0], lane_in};
        end
      end
    end

    assign a_out_o[8*r +: 8] = sh_q[9*(r+1)-2 -: 8];
    assign a_lane_vld_o[r]   = sh_q[9*(r+1)-1];
  end

  assign busy_o           = busy_q;
  assign w_ready_o        = w_ready_q;
  assign a_ready_o        = a_ready_q;
  assign done_o           = done_q;
  assign load_weight_en_o = lwe_q;
  assign sum_out_o        = {24'd0, sum_q};

endmodule

// File: tb/tb_mac_col_feeder.sv
// Bench for mac_col_feeder. The reference is a timeline: each job fills
// per-cycle expectation tables from the protocol rules (ready windows, load
// order, lane delays, flush length), and one negedge process compares every
// output against the table every cycle. Idle cycles expect all zeros.
module tb_mac_col_feeder;

  localparam int ROWS   = 4;
  localparam int FLUSH  = ROWS + 3;
  localparam int MaxCyc = 4096;

  logic                clk = 1'b0;
  logic                rst_i = 1'b1;
  logic                start_i = 1'b0;
  logic [15:0]         k_len_i = '0;
  logic                w_valid_i = 1'b0;
  logic                w_ready_o;
  logic [7:0]          w_data_i = '0;
  logic                a_valid_i = 1'b0;
  logic                a_ready_o;
  logic [8*ROWS-1:0]   a_data_i = '0;
  logic                load_weight_en_o;
  logic [31:0]         sum_out_o;
  logic [8*ROWS-1:0]   a_out_o;
  logic [ROWS-1:0]     a_lane_vld_o;
  logic                busy_o;
  logic                done_o;

  mac_col_feeder #(
    .ROWS      (ROWS),
    .FLUSH_CYC (FLUSH)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .start_i          (start_i),
    .k_len_i          (k_len_i),
    .w_valid_i        (w_valid_i),
    .w_ready_o        (w_ready_o),
    .w_data_i         (w_data_i),
    .a_valid_i        (a_valid_i),
    .a_ready_o        (a_ready_o),
    .a_data_i         (a_data_i),
    .load_weight_en_o (load_weight_en_o),
    .sum_out_o        (sum_out_o),
    .a_out_o          (a_out_o),
    .a_lane_vld_o     (a_lane_vld_o),
    .busy_o           (busy_o),
    .done_o           (done_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected outputs per cycle.
  bit              e_busy [MaxCyc];
  bit              e_wrdy [MaxCyc];
  bit              e_ardy [MaxCyc];
  bit              e_lwe  [MaxCyc];
  bit              e_done [MaxCyc];
  bit [7:0]        e_sum  [MaxCyc];
  bit [8*ROWS-1:0] e_aout [MaxCyc];
  bit [ROWS-1:0]   e_vld  [MaxCyc];

  // Observed DUT outputs, for the literal spot checks.
  logic [8*ROWS-1:0] got_aout [MaxCyc];
  logic [ROWS-1:0]   got_vld  [MaxCyc];
  logic [7:0]        sum_log [$];
  int                done_cyc = -1;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  int last_u, last_z, first_v, rst_cyc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0h required %0h", name, cyc, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mark(input int c);
    if (c >= MaxCyc - 16) begin
      $display("FAIL cycle_budget: got cycle %0d required below %0d", c, MaxCyc - 16);
      $fatal(1);
    end
    e_busy[c] = 1'b1;
  endtask

  // One job. wmode: 0 always valid, 1 toggling, 2 random. amode: 0 always
  // valid, 1 two idle cycles between vectors, 2 random. rst_at >= 0 raises rst
  // on that load cycle and abandons the job.
  task automatic job(input int k, input int wmode, input int amode, input bit spur,
                     input int rst_at, input bit directed);
    bit [7:0]        w [ROWS];
    bit [8*ROWS-1:0] vec;
    int n, c, gap, u, z;
    bit v, tog;
    start_i = 1'b1;
    k_len_i = 16'(k);
    step();
    start_i = 1'b0;
    n = 0; tog = 1'b1; u = 0;
    while (n < ROWS) begin
      c = cyc;
      mark(c);
      e_wrdy[c] = 1'b1;
      case (wmode)
        0:       v = 1'b1;
        1:       v = tog;
        default: v = 1'($urandom_range(0, 1));
      endcase
      tog = ~tog;
      w_valid_i = v;
      w_data_i  = directed ? 8'(8'h11 * (n + 1)) : 8'($urandom);
      if (spur) begin
        start_i = 1'($urandom_range(0, 1));
        k_len_i = 16'($urandom);
      end
      if (v) begin
        w[n] = w_data_i;
        u = c;
        n++;
      end
      step();
    end
    w_valid_i = 1'b0;
    start_i   = 1'b0;
    // Load cycles u+1 .. u+ROWS, weights in reverse row order.
    for (int i = 0; i < ROWS; i++) begin
      c = cyc;
      mark(c);
      e_lwe[c] = 1'b1;
      e_sum[c] = w[ROWS-1-i];
      w_valid_i = 1'($urandom_range(0, 1));
      w_data_i  = 8'($urandom);
      a_valid_i = 1'($urandom_range(0, 1));
      a_data_i  = $urandom;
      if (i == rst_at) begin
        rst_i = 1'b1;
        rst_cyc = c;
      end
      step();
      if (i == rst_at) begin
        rst_i = 1'b0;
        w_valid_i = 1'b0;
        a_valid_i = 1'b0;
        return;
      end
    end
    w_valid_i = 1'b0;
    a_valid_i = 1'b0;
    z = u + ROWS;
    n = 0;
    gap = 0;
    while (n < k) begin
      c = cyc;
      mark(c);
      e_ardy[c] = 1'b1;
      case (amode)
        0:       v = 1'b1;
        1:       v = (gap == 0);
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      vec = directed ? {8'(4*n+4), 8'(4*n+3), 8'(4*n+2), 8'(4*n+1)} : $urandom;
      a_valid_i = v;
      a_data_i  = vec;
      if (spur) begin
        start_i = 1'($urandom_range(0, 1));
        k_len_i = 16'($urandom);
      end
      if (v) begin
        for (int r = 0; r < ROWS; r++) begin
          e_aout[c+1+r][8*r +: 8] = vec[8*r +: 8];
          e_vld[c+1+r][r] = 1'b1;
        end
        if (n == 0) first_v = c;
        z = c;
        n++;
        gap = 2;
      end else begin
        gap--;
      end
      step();
    end
    a_valid_i = 1'b0;
    start_i   = 1'b0;
    for (int i = 1; i <= FLUSH; i++) begin
      c = cyc;
      mark(c);
      if (i == FLUSH) e_done[c] = 1'b1;
      a_valid_i = 1'($urandom_range(0, 1));
      a_data_i  = $urandom;
      step();
    end
    a_valid_i = 1'b0;
    last_u = u;
    last_z = z;
    step();
  endtask

  always @(negedge clk) begin
    if (chk_en && cyc < MaxCyc) begin
      check("busy", busy_o, e_busy[cyc]);
      check("w_ready", w_ready_o, e_wrdy[cyc]);
      check("a_ready", a_ready_o, e_ardy[cyc]);
      check("load_weight_en", load_weight_en_o, e_lwe[cyc]);
      check("done", done_o, e_done[cyc]);
      check("sum_out", sum_out_o, {24'd0, e_sum[cyc]});
      check("a_out", a_out_o, e_aout[cyc]);
      check("a_lane_vld", a_lane_vld_o, e_vld[cyc]);
      got_aout[cyc] = a_out_o;
      got_vld[cyc]  = a_lane_vld_o;
      if (done_o) done_cyc = cyc;
      if (load_weight_en_o) sum_log.push_back(sum_out_o[7:0]);
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish required finish");
    $fatal(1);
  end

  initial begin
    repeat (3) step();
    rst_i = 1'b0;
    chk_en = 1'b1;
    check("rst_busy", busy_o, 0);
    check("rst_a_lane_vld", a_lane_vld_o, 0);
    check("rst_sum_out", sum_out_o, 0);
    step();

    // Fixed weights 0x11..0x44, three fixed vectors, no stalls.
    sum_log.delete();
    job(3, 0, 0, 1'b0, -1, 1'b1);
    check("wload_len", sum_log.size(), 4);
    check("wload_0", sum_log[0], 8'h44);
    check("wload_1", sum_log[1], 8'h33);
    check("wload_2", sum_log[2], 8'h22);
    check("wload_3", sum_log[3], 8'h11);
    check("lane0_v0", got_aout[first_v+1][7:0], 8'h01);
    check("lane3_v0", got_aout[first_v+4][31:24], 8'h04);
    check("lane3_v1", got_aout[first_v+5][31:24], 8'h08);
    check("lane2_v2", got_aout[first_v+5][23:16], 8'h0B);
    check("done_lat_k3", done_cyc - last_z, 7);

    // Two idle cycles between two vectors.
    job(2, 0, 1, 1'b0, -1, 1'b1);
    check("vld_bubble_a", got_vld[first_v+2], 4'b0010);
    check("vld_bubble_b", got_vld[first_v+4], 4'b1001);
    check("aout_bubble", got_aout[first_v+2][7:0], 8'h00);
    check("done_lat_k2", done_cyc - last_z, 7);

    // No vectors: straight from load to flush.
    job(0, 0, 0, 1'b0, -1, 1'b1);
    check("done_lat_k0", done_cyc - (last_u + ROWS), 7);

    // Toggling w_valid, spurious starts, random data.
    job(3, 1, 0, 1'b1, -1, 1'b0);

    // Reset on the second load cycle, then a fresh job.
    done_cyc = -1;
    job(2, 0, 0, 1'b0, 1, 1'b1);
    check("rst_mid_lwe", load_weight_en_o, 0);
    check("rst_mid_busy", busy_o, 0);
    check("rst_mid_sum", sum_out_o, 0);
    repeat (10) step();
    check("rst_no_done", done_cyc, -1);
    job(2, 2, 2, 1'b0, -1, 1'b0);

    for (int j = 0; j < 8; j++) begin
      job($urandom_range(0, 6), 2, 2, 1'b1, -1, 1'b0);
    end
    repeat (4) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
